// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Moore-style sequencer for the multicycle MIPS datapath. It walks each
// instruction through fetch, decode, execute, memory and writeback. In each
// state it drives the shared ALU function code and every datapath select and
// enable. A watchdog aborts any memory access whose mem_ready wait runs too
// long.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   opcode, funct     IR[31:26] and IR[5:0]; IR is stable after FETCH
//   isZero            ALU zero flag (branch decision)
//   mem_ready         memory completes the requested access this cycle
//   mem_req/MemWrite/IorD              memory port request, write, address select
//   IRWrite/PCEn/PCSrc                 IR load, PC load, PC source select
//   ALUSrcA/ALUSrcB/ALUcontrol         ALU operand selects and function code
//   RegDst/MemtoReg/RegWrite           register-file write path
//   instr_done/illegal_instr/mem_error one-cycle status pulses
//   state             current state code (debug)
//
// Parameters
//   TIMEOUT_CYCLES    wait cycles before a memory access is aborted (0 = off)
//   CNT_W             wait counter width, must hold TIMEOUT_CYCLES
module mips_multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       isZero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUcontrol,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       mem_error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_instr;
    logic       mem_error;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam bit             WDOG_EN   = (TIMEOUT_CYCLES > 0);
  // The abort fires on the wait cycle that would bring the count up to
  // TIMEOUT_CYCLES, so the counter itself only ever reaches TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             is_sw, is_sw_nxt;   // MEMADR routing, captured in DECODE
  logic             mem_wait;
  logic             timeout;
  ctl_t             ctl, ctl_o;

  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE)) && !mem_ready;
  // mem_ready wins a tie with the watchdog because mem_wait already requires !mem_ready.
  assign timeout  = WDOG_EN && mem_wait && (cnt == LAST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt     <= '0;
      is_sw   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt     <= cnt_nxt;
      is_sw   <= is_sw_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ctl       = '0;
    state_nxt = state_q;
    is_sw_nxt = is_sw;

    case (state_q)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.alu_ctl   = ALU_ADD;
        ctl.ir_write  = mem_ready;
        ctl.pc_en     = mem_ready;
        if (mem_ready) begin
          state_nxt = S_DECODE;
        end else if (timeout) begin
          ctl.mem_error = 1'b1;
          state_nxt     = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here, while the ALU is otherwise idle.
        ctl.alu_src_b = 2'b11;
        ctl.alu_ctl   = ALU_ADD;
        case (opcode)
          OP_LW: begin
            state_nxt = S_MEMADR;
            is_sw_nxt = 1'b0;
          end
          OP_SW: begin
            state_nxt = S_MEMADR;
            is_sw_nxt = 1'b1;
          end
          OP_RTYPE: begin
            if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
              state_nxt = S_EXECUTE;
            end else begin
              ctl.illegal_instr = 1'b1;
              state_nxt         = S_FETCH;
            end
          end
          OP_BEQ:  state_nxt = S_BRANCH;
          OP_ADDI: state_nxt = S_ADDIEXEC;
          OP_J:    state_nxt = S_JUMP;
          default: begin
            ctl.illegal_instr = 1'b1;
            state_nxt         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_ctl   = ALU_ADD;
        state_nxt     = is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end else if (timeout) begin
          ctl.mem_error = 1'b1;
          state_nxt     = S_FETCH;
        end
      end
      S_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_MEMWRITE: begin
        ctl.mem_req    = 1'b1;
        ctl.iord       = 1'b1;
        ctl.mem_write  = !timeout;
        ctl.instr_done = mem_ready;
        if (mem_ready) begin
          state_nxt = S_FETCH;
        end else if (timeout) begin
          ctl.mem_error = 1'b1;
          state_nxt     = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b00;
        case (funct)
          FN_ADD:  ctl.alu_ctl = ALU_ADD;
          FN_SUB:  ctl.alu_ctl = ALU_SUB;
          FN_AND:  ctl.alu_ctl = ALU_AND;
          FN_OR:   ctl.alu_ctl = ALU_OR;
          FN_SLT:  ctl.alu_ctl = ALU_SLT;
          default: ctl.alu_ctl = ALU_AND;
        endcase
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = 2'b00;
        ctl.alu_ctl    = ALU_SUB;
        ctl.pc_src     = 2'b01;
        ctl.pc_en      = isZero;
        ctl.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_ADDIEXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_ctl   = ALU_ADD;
        state_nxt     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_src     = 2'b10;
        ctl.pc_en      = 1'b1;
        ctl.instr_done = 1'b1;
        state_nxt      = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Any state change or abort starts the next wait count from zero.
    if ((state_nxt != state_q) || timeout) begin
      cnt_nxt = '0;
    end else if (mem_wait) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = cnt;
    end
  end

  // NOTE: outputs are gated by reset combinationally so that no strobe is
  // visible once reset rises, without waiting for the next clock edge.
  assign ctl_o = reset ? '0 : ctl;

  assign mem_req       = ctl_o.mem_req;
  assign MemWrite      = ctl_o.mem_write;
  assign IorD          = ctl_o.iord;
  assign IRWrite       = ctl_o.ir_write;
  assign PCEn          = ctl_o.pc_en;
  assign PCSrc         = ctl_o.pc_src;
  assign ALUSrcA       = ctl_o.alu_src_a;
  assign ALUSrcB       = ctl_o.alu_src_b;
  assign ALUcontrol    = ctl_o.alu_ctl;
  assign RegDst        = ctl_o.reg_dst;
  assign MemtoReg      = ctl_o.mem_to_reg;
  assign RegWrite      = ctl_o.reg_write;
  assign instr_done    = ctl_o.instr_done;
  assign illegal_instr = ctl_o.illegal_instr;
  assign mem_error     = ctl_o.mem_error;
  assign state         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
// Self-checking bench for mips_multicycle_control (watchdog set to 4 cycles).
// Instructions are expanded into per-cycle {inputs, expected outputs} records
// by an instruction-level model. The records are then applied and compared
// one cycle at a time. Directed instructions cover the named corner cases.
// Random instructions with random memory wait lengths follow. A final
// sequence checks asynchronous reset in the middle of MEMREAD.
module tb_mips_multicycle_control;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       isZero, mem_ready;
  logic       mem_req, MemWrite, IorD, IRWrite, PCEn;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUcontrol;
  logic       RegDst, MemtoReg, RegWrite, instr_done, illegal_instr, mem_error;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .isZero(isZero), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUcontrol(ALUcontrol), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .mem_error(mem_error), .state(state)
  );

  typedef struct packed {
    logic       mem_req;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCEn;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUcontrol;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal_instr;
    logic       mem_error;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_BADOP, K_BADFN} kind_e;

  outs_t act;
  assign act = {mem_req, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                ALUcontrol, RegDst, MemtoReg, RegWrite, instr_done,
                illegal_instr, mem_error, state};

  vec_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  outs_t      zero_o = '0;

  task automatic check(input string name, input outs_t got, input outs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
               name, got, got.state, want, want.state, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal_op(logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
  endfunction

  function automatic bit is_legal_fn(logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  function automatic logic [2:0] alu_code(logic [5:0] fn);
    case (fn)
      6'h20:   return 3'd2;
      6'h22:   return 3'd6;
      6'h24:   return 3'd0;
      6'h25:   return 3'd1;
      6'h2A:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Expected output word for each step of an instruction.
  function automatic outs_t o_base(int st);
    outs_t o;
    o = '0;
    o.state = 4'(st);
    return o;
  endfunction

  function automatic outs_t o_fetch(logic rdy, logic ab);
    outs_t o = o_base(0);
    o.mem_req = 1; o.ALUSrcB = 2'b01; o.ALUcontrol = 3'd2;
    o.IRWrite = rdy; o.PCEn = rdy; o.mem_error = ab;
    return o;
  endfunction

  function automatic outs_t o_decode(logic ill);
    outs_t o = o_base(1);
    o.ALUSrcB = 2'b11; o.ALUcontrol = 3'd2; o.illegal_instr = ill;
    return o;
  endfunction

  function automatic outs_t o_memadr();
    outs_t o = o_base(2);
    o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.ALUcontrol = 3'd2;
    return o;
  endfunction

  function automatic outs_t o_read(logic ab);
    outs_t o = o_base(3);
    o.mem_req = 1; o.IorD = 1; o.mem_error = ab;
    return o;
  endfunction

  function automatic outs_t o_write(logic rdy, logic ab);
    outs_t o = o_base(5);
    o.mem_req = 1; o.IorD = 1; o.MemWrite = !ab; o.instr_done = rdy; o.mem_error = ab;
    return o;
  endfunction

  function automatic outs_t o_mem(int kind, logic rdy, logic ab);
    case (kind)
      0:       return o_fetch(rdy, ab);
      1:       return o_read(ab);
      default: return o_write(rdy, ab);
    endcase
  endfunction

  function automatic outs_t o_wb(int st, logic dst, logic m2r);
    outs_t o = o_base(st);
    o.RegDst = dst; o.MemtoReg = m2r; o.RegWrite = 1; o.instr_done = 1;
    return o;
  endfunction

  function automatic outs_t o_alu(int st, logic [1:0] srcb, logic [2:0] ctl);
    outs_t o = o_base(st);
    o.ALUSrcA = 1; o.ALUSrcB = srcb; o.ALUcontrol = ctl;
    return o;
  endfunction

  function automatic outs_t o_beq(logic z);
    outs_t o = o_alu(8, 2'b00, 3'd6);
    o.PCSrc = 2'b01; o.PCEn = z; o.instr_done = 1;
    return o;
  endfunction

  function automatic outs_t o_jump();
    outs_t o = o_base(11);
    o.PCSrc = 2'b10; o.PCEn = 1; o.instr_done = 1;
    return o;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy, input outs_t o);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = o;
    q.push_back(v);
  endtask

  // A memory access that sees mem_ready after 'waits' low cycles, or is
  // aborted on the TMO-th low cycle if the memory would keep it waiting longer.
  task automatic mem_phase(input int kind, input int waits, input logic [5:0] op,
                           input logic [5:0] fn, output bit aborted);
    if (TMO > 0 && waits >= TMO) begin
      for (int i = 0; i < TMO; i++) push(op, fn, rb(), 1'b0, o_mem(kind, 1'b0, i == TMO - 1));
      aborted = 1'b1;
    end else begin
      for (int i = 0; i < waits; i++) push(op, fn, rb(), 1'b0, o_mem(kind, 1'b0, 1'b0));
      push(op, fn, rb(), 1'b1, o_mem(kind, 1'b1, 1'b0));
      aborted = 1'b0;
    end
  endtask

  task automatic add_instr(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw);
    bit ab;
    mem_phase(0, fw, op, fn, ab);
    if (ab) return;
    push(op, fn, rb(), rb(), o_decode(k == K_BADOP || k == K_BADFN));
    case (k)
      K_R: begin
        push(op, fn, rb(), rb(), o_alu(6, 2'b00, alu_code(fn)));
        push(op, fn, rb(), rb(), o_wb(7, 1'b1, 1'b0));
      end
      K_LW: begin
        push(op, fn, rb(), rb(), o_memadr());
        mem_phase(1, mw, op, fn, ab);
        if (!ab) push(op, fn, rb(), rb(), o_wb(4, 1'b0, 1'b1));
      end
      K_SW: begin
        push(op, fn, rb(), rb(), o_memadr());
        mem_phase(2, mw, op, fn, ab);
      end
      K_BEQ:  push(op, fn, z, rb(), o_beq(z));
      K_ADDI: begin
        push(op, fn, rb(), rb(), o_alu(9, 2'b10, 3'd2));
        push(op, fn, rb(), rb(), o_wb(10, 1'b0, 1'b0));
      end
      K_J:    push(op, fn, rb(), rb(), o_jump());
      default: ;
    endcase
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 7) == 0) return $urandom_range(TMO, TMO + 2);
    return $urandom_range(0, TMO - 1);
  endfunction

  task automatic rand_instr();
    kind_e      k;
    logic [5:0] op, fn;
    k  = kind_e'($urandom_range(0, 7));
    fn = 6'($urandom);
    case (k)
      K_R:     begin op = 6'h00; fn = legal_fn[$urandom_range(0, 4)]; end
      K_LW:    op = 6'h23;
      K_SW:    op = 6'h2B;
      K_BEQ:   op = 6'h04;
      K_ADDI:  op = 6'h08;
      K_J:     op = 6'h02;
      K_BADOP: do op = 6'($urandom); while (is_legal_op(op));
      default: begin op = 6'h00; do fn = 6'($urandom); while (is_legal_fn(fn)); end
    endcase
    add_instr(k, op, fn, rb(), rand_wait(), rand_wait());
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are compared
  // on the falling edge.
  task automatic run_queue(input string tag);
    vec_t v;
    int   idx = 0;
    while (q.size() > 0) begin
      v = q.pop_front();
      opcode = v.op; funct = v.fn; isZero = v.z; mem_ready = v.rdy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, idx), act, v.exp);
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; isZero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hold", act, zero_o);
    mem_ready = 1'b1; isZero = 1'b1; opcode = 6'h02;
    #1;
    check("reset_hold_inputs", act, zero_o);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed corner cases.
    foreach (legal_fn[i]) add_instr(K_R, 6'h00, legal_fn[i], 1'b0, 0, 0);
    add_instr(K_LW,    6'h23, 6'h00, 1'b0, 0, 3);
    add_instr(K_BEQ,   6'h04, 6'h00, 1'b1, 0, 0);
    add_instr(K_BEQ,   6'h04, 6'h00, 1'b0, 0, 0);
    add_instr(K_BADOP, 6'h3F, 6'h00, 1'b0, 0, 0);
    add_instr(K_BADFN, 6'h00, 6'h00, 1'b0, 0, 0);
    add_instr(K_SW,    6'h2B, 6'h00, 1'b0, 0, TMO + 5);
    add_instr(K_SW,    6'h2B, 6'h00, 1'b0, 0, TMO - 1);
    add_instr(K_SW,    6'h2B, 6'h00, 1'b0, 0, 0);
    add_instr(K_LW,    6'h23, 6'h00, 1'b0, 0, TMO);
    add_instr(K_ADDI,  6'h08, 6'h00, 1'b0, TMO, 0);
    add_instr(K_ADDI,  6'h08, 6'h00, 1'b0, TMO - 1, 0);
    add_instr(K_J,     6'h02, 6'h00, 1'b0, 0, 0);
    run_queue("dir");

    repeat (150) rand_instr();
    run_queue("rnd");

    // Reset asserted asynchronously in the third MEMREAD cycle of a lw.
    push(6'h23, 6'h00, 1'b0, 1'b1, o_fetch(1'b1, 1'b0));
    push(6'h23, 6'h00, 1'b0, 1'b1, o_decode(1'b0));
    push(6'h23, 6'h00, 1'b0, 1'b1, o_memadr());
    push(6'h23, 6'h00, 1'b0, 1'b0, o_read(1'b0));
    push(6'h23, 6'h00, 1'b0, 1'b0, o_read(1'b0));
    run_queue("rst_pre");
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", act, zero_o);
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_held", act, zero_o);
    @(posedge clk);
    #1;
    reset = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    @(negedge clk);
    check("rst_release", act, o_fetch(1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style sequencer for the multicycle MIPS datapath.
- Drives the shared ALU's 3-bit ALUcontrol code and all datapath mux/enable selects, state by state: fetch, decode, execute, memory, writeback.
- Sits between the instruction register (opcode/funct in), the ALU isZero flag, and a memory port with a ready handshake.
- Includes a memory-wait timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 16: cycles a memory access may wait for mem_ready before abort. 0 disables the watchdog.
- CNT_W, 5: width of the wait counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- isZero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the requested access this cycle.
- mem_req  out  1  memory access requested.
- MemWrite  out  1  access is a write.
- IorD  out  1  0 = PC address, 1 = ALU-register address.
- IRWrite  out  1  load IR.
- PCEn  out  1  load PC.
- PCSrc  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUcontrol  out  3  0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = memory data.
- RegWrite  out  1  register-file write enable.
- instr_done  out  1  one-cycle pulse on the final cycle of an instruction.
- illegal_instr  out  1  one-cycle pulse, unsupported opcode/funct.
- mem_error  out  1  one-cycle pulse on watchdog abort.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, active-high):
  - state = FETCH (0) and wait counter = 0.
  - While reset is high, every output is forced to 0, including state.
  - Reset mid-instruction abandons it; no write strobes assert after reset rises.
- States and encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH.
- Outputs are decoded from state. Any output not listed for a state is 0. PCEn, IRWrite and instr_done also depend on inputs as noted.
- FETCH:
  - mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUcontrol=2, PCSrc=00.
  - IRWrite = PCEn = mem_ready.
  - Go to DECODE when mem_ready=1, else hold.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUcontrol=2 (branch target precompute).
  - Next state by opcode: 0x23/0x2B -> MEMADR, 0x00 -> EXECUTE, 0x04 -> BRANCH, 0x08 -> ADDIEXEC, 0x02 -> JUMP.
  - Opcode 0x00 with funct not in {0x20, 0x22, 0x24, 0x25, 0x2A}, or any other opcode: pulse illegal_instr, go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUcontrol=2. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, IorD=1. Go to MEMWB on mem_ready, else hold.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Go to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, IorD=1. instr_done = mem_ready. Go to FETCH on mem_ready, else hold.
- EXECUTE:
  - ALUSrcA=1, ALUSrcB=00.
  - ALUcontrol from funct: 0x20 -> 2, 0x22 -> 6, 0x24 -> 0, 0x25 -> 1, 0x2A -> 7.
  - Go to ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUcontrol=6, PCSrc=01, PCEn=isZero, instr_done=1. Go to FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUcontrol=2. Go to ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Go to FETCH.
- JUMP: PCSrc=10, PCEn=1, instr_done=1. Go to FETCH.
- Latency with zero-wait memory, in cycles: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3. Each memory wait cycle adds 1.
- Watchdog (memory states FETCH, MEMREAD, MEMWRITE):
  - Counter increments each cycle mem_req=1 and mem_ready=0. It clears on state change.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0: pulse mem_error, go to FETCH, assert no IRWrite/PCEn/RegWrite.
  - If mem_ready arrives in that same cycle, mem_ready wins: normal completion, no error.
  - From MEMWRITE, MemWrite drops on abort.
- opcode/funct are sampled only in DECODE and EXECUTE. The IR is stable after FETCH.

Test Plan:
- Reset asserted mid-MEMREAD: all outputs 0 immediately (asynchronous). After release, state=0, mem_req=1, ALUSrcB=01, ALUcontrol=2.
- add (opcode 0, funct 0x20), mem_ready tied 1: states 0,1,6,7. ALUcontrol=2 in EXECUTE. RegWrite=1 with RegDst=1 in cycle 4. instr_done on cycle 4. Repeat for funct 0x22/0x24/0x25/0x2A -> ALUcontrol 6/0/1/7.
- lw (0x23), mem_ready low for 3 cycles in MEMREAD: states 0,1,2,3,3,3,3,4. RegWrite with MemtoReg=1 once. Total 8 cycles.
- beq (0x04): isZero=1 -> PCEn=1, PCSrc=01, ALUcontrol=6 in state 8. isZero=0 -> PCEn=0. Both take 3 cycles.
- opcode 0x3F, then opcode 0 with funct 0x00: each pulses illegal_instr in DECODE, returns to FETCH, RegWrite never asserts.
- TIMEOUT_CYCLES=4, sw with mem_ready held 0: mem_error pulses after 4 wait cycles, MemWrite drops, state returns to 0. With mem_ready=1 on the 4th wait cycle: instr_done pulses, no mem_error.
